// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared constants and state encodings for the instruction-fetch unit.
package ysyx_22041412_ifu_pkg;

    // Fetch PC after reset
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    // Canonical RISC-V nop (addi x0, x0, 0), shown downstream while nothing is valid
    localparam logic [31:0] IFU_NOP = 32'h0000_0013;

    // Fetch FSM states with fixed 2-bit encodings
    typedef enum logic [1:0] {
        S_REQ  = 2'b00,  // presenting a request to instruction memory
        S_WAIT = 2'b01,  // request accepted, waiting for its response
        S_HOLD = 2'b10,  // instruction buffered, waiting for decode
        S_DROP = 2'b11   // stale request outstanding, its response is discarded
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22041412_pc_reg.sv
// Architectural fetch PC register: redirect load takes priority over +4 increment.
module ysyx_22041412_pc_reg
    import ysyx_22041412_ifu_pkg::*;
#(
    parameter int          PC_W     = 64,
    parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Redirect targets are word aligned; the two low bits are forced to zero.
    logic [PC_W-1:0] load_pc_aligned;
    assign load_pc_aligned = load_pc & ~PC_W'(3);

    // PC update: reset, then redirect load, then sequential increment (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC[PC_W-1:0];
        end else if (load) begin
            pc <= load_pc_aligned;
        end else if (inc) begin
            pc <= pc + PC_W'(4);
        end
    end

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output buffer,
// redirects from execute squash any in-flight or buffered stale instruction.
module ysyx_22041412_ifu
    import ysyx_22041412_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          PC_W     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    input  logic            out_ready
);

    ifu_state_e      state;
    ifu_state_e      state_next;
    logic [PC_W-1:0] pc;
    logic            req_fire;
    logic            pc_inc;
    logic            capture;
    logic            consume;

    // The request is gated by rst_n so nothing is presented while reset is held.
    assign imem_req_valid = rst_n && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A fresh response is buffered only if no redirect makes it stale this cycle.
    assign capture = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign consume = (state == S_HOLD) && out_ready;
    // Redirect has priority: a same-cycle consume does not also advance the PC.
    assign pc_inc  = consume && !redirect_valid;

    ysyx_22041412_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; redirect decides whether an old request is still outstanding
    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_next = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Output buffer: load on a fresh response, clear on consume or redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= IFU_NOP;
            out_pc    <= RESET_PC[PC_W-1:0];
        end else if (capture) begin
            out_valid <= 1'b1;
            out_instr <= imem_resp_data;
            out_pc    <= pc;
        end else if (redirect_valid || consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Directed bench for the fetch stage; inputs change 1 time unit after the rising edge
// and outputs are checked 2 time units after it.
module tb_ysyx_22041412_ifu;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;

    int checks;
    int failures;

    ysyx_22041412_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_ready       (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs may then be changed)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        out_ready       = 1'b0;

        // ---- reset state ----
        tick();
        settle();
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        chk("rst_out_pc", out_pc, 64'h8000_0000);

        // ---- basic fetch, k=1, out_ready=1 ----
        rst_n = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        settle();
        chk("first_req_valid", 64'(imem_req_valid), 64'h1);
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);
        tick();                                   // accepted -> S_WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        out_ready       = 1'b0;
        settle();
        chk("wait_req_valid", 64'(imem_req_valid), 64'h0);
        chk("wait_out_valid", 64'(out_valid), 64'h0);
        tick();                                   // response -> S_HOLD
        imem_resp_valid = 1'b0;
        settle();
        chk("hold_out_valid", 64'(out_valid), 64'h1);
        chk("hold_out_pc", out_pc, 64'h8000_0000);
        chk("hold_out_instr", 64'(out_instr), 64'h0010_0093);

        // ---- backpressure for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("bp_out_valid", 64'(out_valid), 64'h1);
            chk("bp_out_instr", 64'(out_instr), 64'h0010_0093);
            chk("bp_out_pc", out_pc, 64'h8000_0000);
            chk("bp_no_req", 64'(imem_req_valid), 64'h0);
        end
        out_ready = 1'b1;
        tick();                                   // consumed -> S_REQ
        out_ready = 1'b0;
        settle();
        chk("after_consume_out_valid", 64'(out_valid), 64'h0);
        chk("second_req_addr", imem_req_addr, 64'h8000_0004);

        // ---- imem_req_ready low for 4 cycles ----
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("stall_req_valid", 64'(imem_req_valid), 64'h1);
            chk("stall_req_addr", imem_req_addr, 64'h8000_0004);
        end
        imem_req_ready = 1'b1;
        tick();                                   // accepted -> S_WAIT
        imem_req_ready = 1'b0;

        // ---- redirect in S_WAIT, stale response 3 cycles later ----
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();                                   // -> S_DROP
        redirect_valid = 1'b0;
        settle();
        chk("drop_out_valid", 64'(out_valid), 64'h0);
        chk("drop_req_valid", 64'(imem_req_valid), 64'h0);
        tick();
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        settle();
        chk("drop_wait_req_valid", 64'(imem_req_valid), 64'h0);
        tick();                                   // stale word discarded -> S_REQ
        imem_resp_valid = 1'b0;
        settle();
        chk("stale_out_valid", 64'(out_valid), 64'h0);
        chk("stale_not_latched", 64'(out_instr == 32'hDEAD_BEEF), 64'h0);
        chk("redir_req_valid", 64'(imem_req_valid), 64'h1);
        chk("redir_req_addr", imem_req_addr, 64'h8000_0100);
        tick();
        settle();
        chk("stale_out_valid_2", 64'(out_valid), 64'h0);

        // ---- redirect and out_ready in the same S_HOLD cycle ----
        imem_req_ready = 1'b1;
        tick();                                   // -> S_WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();                                   // -> S_HOLD
        imem_resp_valid = 1'b0;
        settle();
        chk("hold2_out_pc", out_pc, 64'h8000_0100);
        chk("hold2_out_instr", 64'(out_instr), 64'h1234_5678);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0042;
        out_ready      = 1'b1;
        tick();                                   // -> S_REQ at aligned target
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        settle();
        chk("hold_redir_out_valid", 64'(out_valid), 64'h0);
        chk("hold_redir_req_valid", 64'(imem_req_valid), 64'h1);
        chk("hold_redir_req_addr", imem_req_addr, 64'h8000_0040);

        // ---- redirect in S_REQ without handshake, then PC wrap ----
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();                                   // stays in S_REQ
        redirect_valid = 1'b0;
        settle();
        chk("req_redir_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("req_redir_valid", 64'(imem_req_valid), 64'h1);
        imem_req_ready = 1'b1;
        tick();                                   // -> S_WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0073;
        tick();                                   // -> S_HOLD
        imem_resp_valid = 1'b0;
        out_ready       = 1'b1;
        settle();
        chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();                                   // consumed -> S_REQ
        out_ready = 1'b0;
        settle();
        chk("wrap_req_addr", imem_req_addr, 64'h0);
        chk("wrap_req_valid", 64'(imem_req_valid), 64'h1);

        // ---- redirect together with request handshake -> S_DROP ----
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        settle();
        chk("req_fire_redir_no_req", 64'(imem_req_valid), 64'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0001;
        tick();                                   // discarded -> S_REQ
        imem_resp_valid = 1'b0;
        settle();
        chk("req_fire_redir_out_valid", 64'(out_valid), 64'h0);
        chk("req_fire_redir_addr", imem_req_addr, 64'h8000_0200);

        // ---- redirect in S_WAIT with a same-cycle response ----
        imem_req_ready = 1'b1;
        tick();                                   // -> S_WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0002;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_0300;
        tick();                                   // response discarded -> S_REQ
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        settle();
        chk("wait_resp_redir_out_valid", 64'(out_valid), 64'h0);
        chk("wait_resp_redir_req_valid", 64'(imem_req_valid), 64'h1);
        chk("wait_resp_redir_addr", imem_req_addr, 64'h8000_0300);

        // ---- reset asserted in S_WAIT ----
        imem_req_ready = 1'b1;
        tick();                                   // -> S_WAIT
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        settle();
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("midrst_out_pc", out_pc, 64'h8000_0000);
        tick();
        rst_n = 1'b1;
        settle();
        chk("restart_req_valid", 64'(imem_req_valid), 64'h1);
        chk("restart_req_addr", imem_req_addr, 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
